// File: rtl/comm_request_gen_if.sv
// Load-request handshake between the modulator and comm_request_gen.
interface comm_request_gen_if;
  logic [1:0] req_load;
  logic       req_valid;
  logic       req_ready;

  modport master (output req_load, output req_valid, input req_ready);
  modport slave  (input req_load, input req_valid, output req_ready);
endinterface

// File: rtl/comm_request_gen.sv
// Debounced current-sign detector plus paced DesiredLoad sequencer for the commutation FSM.
// Optional: COMM_DEFER_TIMEOUT_EN forces a deferred load change after DEFER_MAX cycles.
module comm_request_gen #(
  parameter int unsigned IW          = 12,
  parameter int unsigned THRESH      = 16,
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned HOLD_CYCLES = 16
`ifdef COMM_DEFER_TIMEOUT_EN
  , parameter int unsigned DEFER_MAX = 256
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [IW-1:0] i_sample,
  input  logic                 i_valid,
  comm_request_gen_if.slave    req,
  output logic [1:0]           desired_load,
  output logic                 current_sign,
  output logic                 sign_valid,
  output logic                 in_deadband
`ifdef COMM_DEFER_TIMEOUT_EN
  , output logic               defer_timeout
`endif
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam logic signed [IW-1:0] POS_TH = IW'(THRESH);
  localparam logic signed [IW-1:0] NEG_TH = -POS_TH;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DEFER} state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_desired, w_desired_nxt;
  logic [1:0]      r_pending, w_pending_nxt;
  logic [HW-1:0]   r_hold_cnt, w_hold_nxt;
  logic [CW-1:0]   r_deb_cnt;
  logic            r_sign, r_sign_valid, r_in_deadband, r_req_ready;
  logic            w_pos, w_neg, w_reliable;

  // Signed compares keep the most-negative sample on the negative side
  assign w_pos      = (i_sample >= POS_TH);
  assign w_neg      = (i_sample <= NEG_TH);
  assign w_reliable = r_sign_valid & ~r_in_deadband;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign        <= 1'b0;
      r_sign_valid  <= 1'b0;
      r_in_deadband <= 1'b1;
      r_deb_cnt     <= '0;
    end else if (i_valid) begin
      if (!w_pos && !w_neg) begin
        r_in_deadband <= 1'b1;
        r_deb_cnt     <= '0;
      end else begin
        r_in_deadband <= 1'b0;
        if (r_sign_valid && (w_pos == r_sign)) begin
          r_deb_cnt <= '0;
        end else if (r_deb_cnt == CW'(DEBOUNCE - 1)) begin
          r_sign       <= w_pos;
          r_sign_valid <= 1'b1;
          r_deb_cnt    <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + CW'(1);
        end
      end
    end
  end

`ifdef COMM_DEFER_TIMEOUT_EN
  localparam int unsigned DW = $clog2(DEFER_MAX + 1);
  logic [DW-1:0] r_defer_cnt, w_defer_nxt;
  logic          r_defer_timeout, w_timeout_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_desired   <= 2'b00;
      r_pending   <= 2'b00;
      r_hold_cnt  <= '0;
      r_req_ready <= 1'b1;
`ifdef COMM_DEFER_TIMEOUT_EN
      r_defer_cnt     <= '0;
      r_defer_timeout <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_desired   <= w_desired_nxt;
      r_pending   <= w_pending_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_req_ready <= (w_state_nxt == S_IDLE);
`ifdef COMM_DEFER_TIMEOUT_EN
      r_defer_cnt     <= w_defer_nxt;
      r_defer_timeout <= w_timeout_nxt;
`endif
    end
  end

  // Sequencer: NUL or same-load requests are no-ops; phase changes wait for a reliable sign
  always_comb begin
    w_state_nxt   = r_state;
    w_desired_nxt = r_desired;
    w_pending_nxt = r_pending;
    w_hold_nxt    = r_hold_cnt;
`ifdef COMM_DEFER_TIMEOUT_EN
    w_defer_nxt   = r_defer_cnt;
    w_timeout_nxt = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (req.req_valid && (req.req_load != 2'b00) && (req.req_load != r_desired)) begin
          if ((r_desired == 2'b00) || w_reliable) begin
            w_desired_nxt = req.req_load;
            w_hold_nxt    = HW'(HOLD_CYCLES - 1);
            w_state_nxt   = S_HOLD;
          end else begin
            w_pending_nxt = req.req_load;
            w_state_nxt   = S_DEFER;
`ifdef COMM_DEFER_TIMEOUT_EN
            w_defer_nxt   = '0;
`endif
          end
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_hold_nxt = r_hold_cnt - HW'(1);
        end
      end
      S_DEFER: begin
        if (w_reliable) begin
          w_desired_nxt = r_pending;
          w_hold_nxt    = HW'(HOLD_CYCLES - 1);
          w_state_nxt   = S_HOLD;
`ifdef COMM_DEFER_TIMEOUT_EN
        end else if (r_defer_cnt == DW'(DEFER_MAX - 1)) begin
          w_desired_nxt = r_pending;
          w_hold_nxt    = HW'(HOLD_CYCLES - 1);
          w_state_nxt   = S_HOLD;
          w_timeout_nxt = 1'b1;
        end else begin
          w_defer_nxt = r_defer_cnt + DW'(1);
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign req.req_ready  = r_req_ready;
  assign desired_load   = r_desired;
  assign current_sign   = r_sign;
  assign sign_valid     = r_sign_valid;
  assign in_deadband    = r_in_deadband;
`ifdef COMM_DEFER_TIMEOUT_EN
  assign defer_timeout  = r_defer_timeout;
`endif

endmodule

// File: tb/tb_comm_request_gen.sv
// Table-driven, scoreboarded bench for comm_request_gen (both COMM_DEFER_TIMEOUT_EN builds).
module tb_comm_request_gen;

  typedef struct {
    logic [1:0] dl;
    logic       sg;
    logic       sv;
    logic       db;
    logic       rdy;
    logic       to;
  } exp_t;

  typedef struct {
    logic signed [11:0] smp;
    logic               vld;
    logic [1:0]         rl;
    logic               rv;
    exp_t               e;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [11:0] i_sample = '0;
  logic               i_valid = 1'b0;
  logic [1:0]         desired_load;
  logic               current_sign, sign_valid, in_deadband;
  logic               defer_timeout;
  comm_request_gen_if req_if();

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  vec_t tbl[26];

  always #5 clk = ~clk;

`ifdef COMM_DEFER_TIMEOUT_EN
  comm_request_gen #(.IW(12), .THRESH(16), .DEBOUNCE(4), .HOLD_CYCLES(16), .DEFER_MAX(8)) dut (
    .clk(clk), .rst(rst), .i_sample(i_sample), .i_valid(i_valid), .req(req_if.slave),
    .desired_load(desired_load), .current_sign(current_sign), .sign_valid(sign_valid),
    .in_deadband(in_deadband), .defer_timeout(defer_timeout));
`else
  comm_request_gen #(.IW(12), .THRESH(16), .DEBOUNCE(4), .HOLD_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .i_sample(i_sample), .i_valid(i_valid), .req(req_if.slave),
    .desired_load(desired_load), .current_sign(current_sign), .sign_valid(sign_valid),
    .in_deadband(in_deadband));
  assign defer_timeout = 1'b0;
`endif

  function automatic exp_t mk(input logic [1:0] dl, input logic sg, input logic sv,
                              input logic db, input logic rdy);
    exp_t r;
    r.dl = dl; r.sg = sg; r.sv = sv; r.db = db; r.rdy = rdy; r.to = 1'b0;
    return r;
  endfunction

  function automatic vec_t vv(input logic signed [11:0] s, input logic vld,
                              input logic [1:0] rl, input logic rv, input exp_t e);
    vec_t r;
    r.smp = s; r.vld = vld; r.rl = rl; r.rv = rv; r.e = e;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle, push expected outputs, compare after the edge
  task automatic cyc(input logic signed [11:0] smp, input logic vld, input logic [1:0] rl,
                     input logic rv, input exp_t e);
    exp_t x;
    i_sample = smp; i_valid = vld; req_if.req_load = rl; req_if.req_valid = rv;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("desired_load", desired_load, x.dl);
    chk("current_sign", 2'(current_sign), 2'(x.sg));
    chk("sign_valid", 2'(sign_valid), 2'(x.sv));
    chk("in_deadband", 2'(in_deadband), 2'(x.db));
    chk("req_ready", 2'(req_if.req_ready), 2'(x.rdy));
`ifdef COMM_DEFER_TIMEOUT_EN
    chk("defer_timeout", 2'(defer_timeout), 2'(x.to));
`endif
  endtask

  task automatic idle(input exp_t e);
    cyc(12'sd0, 1'b0, 2'b00, 1'b0, e);
  endtask

  task automatic hold_wait(input logic [1:0] dl, input logic sg, input logic sv, input logic db);
    for (int k = 0; k < 15; k++) idle(mk(dl, sg, sv, db, 1'b0));
    idle(mk(dl, sg, sv, db, 1'b1));
  endtask

  initial begin
    logic signed [11:0] mneg;
    exp_t e;
    mneg = 12'sh800;
    req_if.req_load = 2'b00; req_if.req_valid = 1'b0;

    tbl[0]  = vv(12'sd100,   1, 2'b00, 0, mk(0, 0, 0, 0, 1));
    tbl[1]  = vv(12'sd100,   1, 2'b00, 0, mk(0, 0, 0, 0, 1));
    tbl[2]  = vv(12'sd100,   1, 2'b00, 0, mk(0, 0, 0, 0, 1));
    tbl[3]  = vv(12'sd100,   1, 2'b00, 0, mk(0, 1, 1, 0, 1));
    tbl[4]  = vv(-12'sd100,  1, 2'b00, 0, mk(0, 1, 1, 0, 1));
    tbl[5]  = vv(-12'sd100,  1, 2'b00, 0, mk(0, 1, 1, 0, 1));
    tbl[6]  = vv(12'sd5,     1, 2'b00, 0, mk(0, 1, 1, 1, 1));
    tbl[7]  = vv(-12'sd100,  1, 2'b00, 0, mk(0, 1, 1, 0, 1));
    tbl[8]  = vv(-12'sd100,  1, 2'b00, 0, mk(0, 1, 1, 0, 1));
    tbl[9]  = vv(-12'sd100,  1, 2'b00, 0, mk(0, 1, 1, 0, 1));
    tbl[10] = vv(-12'sd100,  1, 2'b00, 0, mk(0, 0, 1, 0, 1));
    tbl[11] = vv(mneg,       0, 2'b00, 0, mk(0, 0, 1, 0, 1));
    tbl[12] = vv(mneg,       1, 2'b00, 0, mk(0, 0, 1, 0, 1));
    tbl[13] = vv(12'sd15,    1, 2'b00, 0, mk(0, 0, 1, 1, 1));
    tbl[14] = vv(-12'sd15,   1, 2'b00, 0, mk(0, 0, 1, 1, 1));
    tbl[15] = vv(-12'sd16,   1, 2'b00, 0, mk(0, 0, 1, 0, 1));
    tbl[16] = vv(12'sd16,    1, 2'b00, 0, mk(0, 0, 1, 0, 1));
    tbl[17] = vv(12'sd16,    1, 2'b00, 0, mk(0, 0, 1, 0, 1));
    tbl[18] = vv(12'sd16,    1, 2'b00, 0, mk(0, 0, 1, 0, 1));
    tbl[19] = vv(12'sd16,    1, 2'b00, 0, mk(0, 1, 1, 0, 1));
    tbl[20] = vv(mneg,       1, 2'b00, 0, mk(0, 1, 1, 0, 1));
    tbl[21] = vv(mneg,       1, 2'b00, 0, mk(0, 1, 1, 0, 1));
    tbl[22] = vv(mneg,       1, 2'b00, 0, mk(0, 1, 1, 0, 1));
    tbl[23] = vv(mneg,       1, 2'b00, 0, mk(0, 0, 1, 0, 1));
    tbl[24] = vv(12'sd0,     0, 2'b00, 1, mk(0, 0, 1, 0, 1));
    tbl[25] = vv(12'sd0,     0, 2'b01, 1, mk(1, 0, 1, 0, 0));

    // Reset values
    rst = 1'b1;
    idle(mk(0, 0, 0, 1, 1));
    idle(mk(0, 0, 0, 1, 1));
    rst = 1'b0;

    for (int i = 0; i < 26; i++) cyc(tbl[i].smp, tbl[i].vld, tbl[i].rl, tbl[i].rv, tbl[i].e);

    // Request 10 held through HOLD: accepted only after req_ready returns
    for (int k = 0; k < 15; k++) cyc(12'sd0, 1'b0, 2'b10, 1'b1, mk(1, 0, 1, 0, 0));
    cyc(12'sd0, 1'b0, 2'b10, 1'b1, mk(1, 0, 1, 0, 1));
    cyc(12'sd0, 1'b0, 2'b10, 1'b1, mk(2, 0, 1, 0, 0));
    hold_wait(2, 0, 1, 0);

    // Same-load and NUL requests are no-ops
    cyc(12'sd0, 1'b0, 2'b10, 1'b1, mk(2, 0, 1, 0, 1));
    cyc(12'sd0, 1'b0, 2'b00, 1'b1, mk(2, 0, 1, 0, 1));

    // Deadband defers the change until an out-of-band sample arrives
    cyc(12'sd3, 1'b1, 2'b00, 1'b0, mk(2, 0, 1, 1, 1));
    cyc(12'sd0, 1'b0, 2'b11, 1'b1, mk(2, 0, 1, 1, 0));
    for (int k = 0; k < 3; k++) idle(mk(2, 0, 1, 1, 0));
    cyc(12'sd50, 1'b1, 2'b00, 1'b0, mk(2, 0, 1, 0, 0));
    idle(mk(3, 0, 1, 0, 0));

    // Reset mid-HOLD
    for (int k = 0; k < 4; k++) idle(mk(3, 0, 1, 0, 0));
    rst = 1'b1;
    idle(mk(0, 0, 0, 1, 1));
    rst = 1'b0;

    // First selection needs no sign; a later change with no valid sign defers
    cyc(12'sd0, 1'b0, 2'b01, 1'b1, mk(1, 0, 0, 1, 0));
    hold_wait(1, 0, 0, 1);
    cyc(12'sd0, 1'b0, 2'b10, 1'b1, mk(1, 0, 0, 1, 0));
`ifdef COMM_DEFER_TIMEOUT_EN
    for (int k = 0; k < 7; k++) idle(mk(1, 0, 0, 1, 0));
    e = mk(2, 0, 0, 1, 0);
    e.to = 1'b1;
    idle(e);
    hold_wait(2, 0, 0, 1);
    cyc(12'sd0, 1'b0, 2'b01, 1'b1, mk(2, 0, 0, 1, 0));
    for (int k = 0; k < 3; k++) idle(mk(2, 0, 0, 1, 0));
`else
    e = mk(1, 0, 0, 1, 0);
    for (int k = 0; k < 1000; k++) idle(e);
`endif

    // Reset mid-DEFER discards the pending load
    rst = 1'b1;
    idle(mk(0, 0, 0, 1, 1));
    rst = 1'b0;
    for (int k = 0; k < 4; k++) idle(mk(0, 0, 0, 1, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/comm_request_gen.md
Name: comm_request_gen

Overview:
- Upstream stage of the four-step commutation FSM.
- Turns raw phase-current ADC samples into a debounced current-sign bit with hysteresis.
- Turns modulator load-select requests into a paced DesiredLoad code. Each code is held long enough for the downstream FSM to finish its commutation sequence.
- Changes between active phases are deferred while the current sign is unreliable, i.e. near a zero crossing.

Parameters:
- IW, 12, width of the signed current sample.
- THRESH, 16, hysteresis magnitude in LSBs. |sample| < THRESH counts as deadband.
- DEBOUNCE, 4, consecutive out-of-band samples of the opposite polarity needed to flip the sign.
- HOLD_CYCLES, 16, minimum clk cycles desired_load stays constant after a change.
- DEFER_MAX, 256, deferral timeout in clk cycles. Used only with COMM_DEFER_TIMEOUT_EN.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- i_sample, input, IW, signed two's-complement phase current.
- i_valid, input, 1, i_sample qualifier, one cycle per sample.
- req_load, input, 2, requested load: 01 = A, 10 = B, 11 = C, 00 = NUL.
- req_valid, input, 1, request valid.
- req_ready, output, 1, block can accept a request.
- desired_load, output, 2, to the commutation FSM DesiredLoad input.
- current_sign, output, 1, to the commutation FSM CurrentSign input. 1 = positive.
- sign_valid, output, 1, at least one sign has been committed since reset.
- in_deadband, output, 1, the last sample was inside ±THRESH.
- defer_timeout, output, 1, one-cycle pulse. Exists only with COMM_DEFER_TIMEOUT_EN.

Behaviour:
- Reset is synchronous, active-high on rst, clock clk.
- Reset values: desired_load = 00, current_sign = 0, sign_valid = 0, in_deadband = 1, req_ready = 1, defer_timeout = 0. State = IDLE; all counters = 0; pending register = 00.
- rst overrides every other event in the same cycle, including during HOLD or DEFER. A pending request is discarded.
- All outputs are registered.

Sign detector (acts only on i_valid cycles):
- Classification uses a signed compare and is correct for the most-negative sample value.
  - sample >= THRESH → positive candidate.
  - sample <= -THRESH → negative candidate.
  - otherwise → deadband.
- Deadband sample: in_deadband <= 1, debounce counter cleared, current_sign held.
- Out-of-band sample: in_deadband <= 0.
  - Candidate equal to current_sign while sign_valid = 1: counter cleared.
  - Otherwise: counter increments.
  - When the counter reaches DEBOUNCE: current_sign <= candidate, sign_valid <= 1, counter cleared.
- The first commit after reset also requires DEBOUNCE samples. This applies even when the candidate is 0.
- Counter width is clog2(DEBOUNCE+1). The counter never wraps.

Load sequencer FSM (states IDLE, HOLD, DEFER):
- IDLE: req_ready = 1. On req_valid (handshake at that edge):
  - req_load = 00 or req_load = desired_load: no-op; stay in IDLE. NUL means "hold" to the downstream FSM.
  - desired_load = 00 (first selection after reset): desired_load <= req_load at that edge; go to HOLD.
  - Change between two active phases with sign_valid = 1 and in_deadband = 0: desired_load <= req_load at that edge; go to HOLD.
  - Change between two active phases otherwise: latch pending <= req_load; go to DEFER.
- HOLD: req_ready = 0. Down-counter loaded with HOLD_CYCLES-1, decremented each cycle. At 0, go to IDLE. desired_load therefore stays stable for exactly HOLD_CYCLES cycles before the next request can be accepted.
- DEFER: req_ready = 0. Each cycle, if sign_valid = 1 and in_deadband = 0, then desired_load <= pending; go to HOLD.
- Decisions use the registered sign_valid and in_deadband values. A sample arriving in the same cycle affects the decision one cycle later.
- Latency: handshake at edge N → desired_load is new after edge N. req_ready is low from edge N to edge N+HOLD_CYCLES.

Optional Feature:
COMM_DEFER_TIMEOUT_EN
- Defined:
  - A defer counter clears on DEFER entry and counts each cycle in DEFER.
  - On reaching DEFER_MAX-1 with the sign still unreliable: desired_load <= pending, defer_timeout pulses for 1 cycle, go to HOLD.
  - If the sign becomes reliable in the same cycle, the normal path applies without the pulse.
- Undefined: DEFER waits indefinitely; the defer_timeout port and the defer counter do not exist.

Test Plan:
- Reset, then 4 samples of +100 with i_valid → after the 4th valid edge, current_sign = 1, sign_valid = 1, in_deadband = 0. After 3 samples, sign_valid is still 0.
- Sign = 1, then samples -100, -100, +5, -100, -100, -100 → the +5 sample sets in_deadband = 1 and clears the count. current_sign flips to 0 only after the 4th consecutive -100.
- Sign valid, out of band, req_load = 01 accepted from reset → desired_load = 01 next edge. req_ready low for 16 cycles. A req_load = 10 asserted during HOLD is not accepted until req_ready returns to 1.
- desired_load = 01, last sample +3 (deadband), request 11 → DEFER, desired_load stays 01. Sample +50 arrives → desired_load = 11 one cycle after in_deadband falls, then HOLD.
- With COMM_DEFER_TIMEOUT_EN and DEFER_MAX = 8, deadband maintained → desired_load changes and defer_timeout = 1 for exactly one cycle, 8 cycles after DEFER entry. Without the macro, still in DEFER after 1000 cycles.
- rst asserted mid-HOLD and mid-DEFER → next edge: desired_load = 00, req_ready = 1, sign_valid = 0, pending discarded.
